oled_spi_receiver: RTL
======================

Name: oled_spi_receiver

Overview:
- Display-side receiver for the OLED serial command link (SDIN/SCLK/DC/RES) driven by Main.
- Oversamples the link with clkX4 and rebuilds MSB-first bytes, each tagged command or data.
- Queues bytes in a small FIFO with a valid/ready output, and keeps traffic counters and sticky error flags.
- Used in MainSim and on-board debug to check OLED traffic without a panel.

Parameters:
FIFO_DEPTH, 8, entries in byte FIFO (power of two, >=2)
IDLE_TIMEOUT, 64, clkX4 cycles without an SCLK rise mid-byte before the partial byte is discarded
CNT_WIDTH, 16, width of cmdCount/dataCount

Ports:
clkX4  in  1  sole clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
SDIN  in  1  serial data, asynchronous to clkX4
SCLK  in  1  serial clock, asynchronous; idles low; data valid on rising edge
DC  in  1  0 = command byte, 1 = data byte; sampled with bit 0 (last bit)
RES  in  1  OLED reset, active-low, asynchronous
byteOut  out  8  FIFO head byte
byteIsData  out  1  DC tag of FIFO head
byteValid  out  1  FIFO non-empty
byteReady  in  1  consumer accepts head when byteValid & byteReady
cmdCount  out  CNT_WIDTH  accepted command bytes, saturating
dataCount  out  CNT_WIDTH  accepted data bytes, saturating
overflow  out  1  sticky: byte dropped because FIFO full
framingError  out  1  sticky: partial byte discarded (timeout or RES low)

Behaviour:
- Reset (rst=1 at a clkX4 edge):
  - Outputs: byteValid=0, byteOut=0, byteIsData=0, counters=0, overflow=0, framingError=0.
  - Internal: FIFO empty, bitCnt=0, shift register=0, synchronizers=0, state=IDLE.
  - rst mid-byte discards the partial byte without setting framingError.
- Synchronisation and edge detect:
  - SDIN, SCLK, DC and RES each pass through a 2-flop synchronizer of equal depth.
  - rise = sclkSync2 & !sclkPrev.
- Latency: edge E0 first samples SCLK=1. rise is active at edge E2, which shifts the bit in. If that bit completes the byte, the FIFO is written at E2 and byteValid is high after E2 when the FIFO was empty.
- Link timing: SCLK high and low each >=3 clkX4 cycles; SDIN/DC stable >=3 cycles before and 1 cycle after each SCLK rise.
- State machine:
  - IDLE: bitCnt=0, waiting. On rise: shift in SDIN, bitCnt=1, go to SHIFT, clear idleCnt.
  - SHIFT, on rise: shiftReg={shiftReg[6:0],SDIN}, idleCnt cleared.
  - SHIFT, bitCnt==7 on rise: push {DCsync, byte}, bitCnt=0, go to IDLE.
  - SHIFT, no rise: idleCnt++. At idleCnt==IDLE_TIMEOUT-1: discard, framingError=1, go to IDLE.
  - RES (synced) low, any state: bitCnt=0, shift register cleared, state=IDLE.
    - framingError=1 only if bitCnt!=0.
    - FIFO contents, counters and rises while RES is low are ignored.
- FIFO:
  - Push when a byte completes. Pop when byteValid & byteReady.
  - Full and no pop: byte dropped, overflow=1, counters unchanged.
  - Full with simultaneous pop: push accepted, occupancy unchanged.
  - Empty with push: no bypass; byte visible the next cycle.
  - byteOut/byteIsData are stable while byteValid=1 and not popped.
  - Pointer wrap-around is modulo FIFO_DEPTH; occupancy uses an extra pointer bit.
- Counters: increment only on accepted push, selected by the DC tag. Saturate at all-ones.
- overflow and framingError clear only on rst.

Test Plan:
- Command byte: send 0xAE with DC=0, SCLK period 8 clkX4, byteReady=1 -> one pop of byteOut=0xAE, byteIsData=0; cmdCount=1, dataCount=0; byteValid high exactly one cycle.
- Back-to-back: send 0x21 (DC=0) then 0x00,0xFF,0x5A (DC=1), byteReady=0 -> FIFO holds 4 entries in order; dataCount=3, cmdCount=1; draining with byteReady=1 pops all four in order.
- Overflow: byteReady=0, send FIFO_DEPTH+2 bytes 0x01.. -> first 8 retained (0x01..0x08), overflow=1, counter total=8; a pop concurrent with a push at full is accepted.
- Timeout: 5 bits then SCLK idle 64 cycles -> framingError=1, nothing pushed; next full byte 0xC3 is received intact.
- RES/rst mid-byte: pull RES low after 3 bits -> partial discarded, framingError=1, FIFO unchanged. Assert rst mid-byte -> all outputs 0, framingError=0.
- Saturation: force 65536 data bytes (or CNT_WIDTH=4 with 17 bytes) -> dataCount holds all-ones.

Source files
------------

// File: rtl/oled_spi_receiver_if.sv
// Byte stream out of the OLED link receiver: head byte, DC tag, valid/ready.
// The receiver drives it as master; the consumer owns byteReady.
interface oled_spi_receiver_if;
  logic [7:0] byteOut;
  logic       byteIsData;
  logic       byteValid;
  logic       byteReady;

  modport master (output byteOut, output byteIsData, output byteValid, input byteReady);
  modport slave  (input byteOut, input byteIsData, input byteValid, output byteReady);
endinterface

// File: rtl/oled_spi_receiver.sv
// OLED serial link receiver: bytes land in the FIFO 2 edges after SCLK rise is first sampled.
// Backpressure via byteReady; bytes arriving at a full FIFO without a pop are dropped (sticky overflow).
module oled_spi_receiver #(
  parameter int FIFO_DEPTH   = 8,
  parameter int IDLE_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clkX4,
  input  logic                 rst,
  input  logic                 SDIN,
  input  logic                 SCLK,
  input  logic                 DC,
  input  logic                 RES,
  oled_spi_receiver_if.master  byte_if,
  output logic [CNT_WIDTH-1:0] cmdCount,
  output logic [CNT_WIDTH-1:0] dataCount,
  output logic                 overflow,
  output logic                 framingError
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(IDLE_TIMEOUT);
  localparam logic [AW:0]          PTR_ONE  = 1;
  localparam logic [IW-1:0]        IDLE_ONE = 1;
  localparam logic [IW-1:0]        IDLE_MAX = IW'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic [3:0]      sync1_q, sync2_q;
  logic            sclk_prev_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [8:0]      mem_q [FIFO_DEPTH];
  logic            sdin_s, sclk_s, dc_s, res_s, rise;
  logic            push, fe_set, pop, push_ok, full, empty;
  logic [8:0]      push_dat;

  assign {sdin_s, sclk_s, dc_s, res_s} = sync2_q;
  assign rise     = sclk_s & ~sclk_prev_q;
  assign push_dat = {dc_s, shift_q[6:0], sdin_s};

  always_ff @(posedge clkX4) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      idle_q      <= '0;
    end else begin
      sync1_q     <= {SDIN, SCLK, DC, RES};
      sync2_q     <= sync1_q;
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      idle_q      <= idle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    idle_d    = idle_q;
    push      = 1'b0;
    fe_set    = 1'b0;
    // Panel reset wins over everything; only a partial byte counts as a framing error.
    if (!res_s) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      idle_d    = '0;
      fe_set    = (bit_cnt_q != 3'd0);
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            shift_d   = {shift_q[6:0], sdin_s};
            bit_cnt_d = 3'd1;
            idle_d    = '0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (rise) begin
            shift_d = {shift_q[6:0], sdin_s};
            idle_d  = '0;
            if (bit_cnt_q == 3'd7) begin
              push      = 1'b1;
              bit_cnt_d = '0;
              state_d   = IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else if (idle_q == IDLE_MAX) begin
            fe_set    = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '0;
            idle_d    = '0;
            state_d   = IDLE;
          end else begin
            idle_d = idle_q + IDLE_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = byte_if.byteValid & byte_if.byteReady;
  assign push_ok = push & (~full | pop);

  assign byte_if.byteValid = ~empty;
  assign {byte_if.byteIsData, byte_if.byteOut} = empty ? 9'd0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clkX4) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clkX4) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cmdCount     <= '0;
      dataCount    <= '0;
      overflow     <= 1'b0;
      framingError <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push_ok && push_dat[8] && dataCount != '1) dataCount <= dataCount + CNT_ONE;
      if (push_ok && !push_dat[8] && cmdCount != '1) cmdCount <= cmdCount + CNT_ONE;
      if (push && full && !pop) overflow <= 1'b1;
      if (fe_set) framingError <= 1'b1;
    end
  end
endmodule
